// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: issues one 8-byte ICache request at a time, applies
// backend redirects, drops stale responses and presents the fetched pair to IF.
module fetch_ctrl #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'h1c000000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              icache_req_valid,
    input  logic              icache_req_ready,
    output logic [ADDR_W-1:0] icache_req_addr,
    input  logic              icache_resp_valid,
    input  logic [31:0]       icache_resp_inst1,
    input  logic [31:0]       icache_resp_inst2,
    output logic [31:0]       inst_1_o,
    output logic [31:0]       inst_2_o,
    output logic [ADDR_W-1:0] pc_1_o,
    output logic [ADDR_W-1:0] pc_2_o,
    output logic              valid_1_o,
    output logic              valid_2_o,
    output logic              flush_o
);

    localparam int unsigned INST_W = 32;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_OUT     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   inst_1_q, inst_1_d;
    logic [INST_W-1:0]   inst_2_q, inst_2_d;
    logic [ADDR_W-1:0]   pc_1_q, pc_1_d;
    logic [ADDR_W-1:0]   pc_2_q, pc_2_d;
    logic                valid_1_q, valid_1_d;
    logic                valid_2_q, valid_2_d;

    logic [ADDR_W-1:0]   redirect_aligned;
    logic [ADDR_W-1:0]   pc_step;
    logic [1:0]          redirect_lsb_unused;

    // Redirect targets are word aligned; the low two bits carry no meaning.
    assign redirect_aligned    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign redirect_lsb_unused = redirect_pc[1:0];

    // An odd-word fetch only delivers one instruction, so advance by 4 instead of 8.
    assign pc_step = pc_q[2] ? ADDR_W'(4) : ADDR_W'(8);

    assign icache_req_addr = {pc_q[ADDR_W-1:3], 3'b000};
    assign flush_o         = redirect_valid;

    assign inst_1_o  = inst_1_q;
    assign inst_2_o  = inst_2_q;
    assign pc_1_o    = pc_1_q;
    assign pc_2_o    = pc_2_q;
    assign valid_1_o = valid_1_q;
    assign valid_2_o = valid_2_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_1_q  <= '0;
            inst_2_q  <= '0;
            pc_1_q    <= '0;
            pc_2_q    <= '0;
            valid_1_q <= 1'b0;
            valid_2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_1_q  <= inst_1_d;
            inst_2_q  <= inst_2_d;
            pc_1_q    <= pc_1_d;
            pc_2_q    <= pc_2_d;
            valid_1_q <= valid_1_d;
            valid_2_q <= valid_2_d;
        end
    end

    // Next-state, request handshake and IF-register update.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inst_1_d         = inst_1_q;
        inst_2_d         = inst_2_q;
        pc_1_d           = pc_1_q;
        pc_2_d           = pc_2_q;
        valid_1_d        = valid_1_q;
        valid_2_d        = valid_2_q;
        icache_req_valid = 1'b0;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                end else begin
                    icache_req_valid = 1'b1;
                    if (icache_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_aligned;
                    state_d = icache_resp_valid ? S_REQ : S_DISCARD;
                end else if (icache_resp_valid) begin
                    inst_1_d  = pc_q[2] ? icache_resp_inst2 : icache_resp_inst1;
                    inst_2_d  = pc_q[2] ? INST_W'(0) : icache_resp_inst2;
                    pc_1_d    = pc_q;
                    pc_2_d    = pc_q + ADDR_W'(4);
                    valid_1_d = 1'b1;
                    valid_2_d = ~pc_q[2];
                    state_d   = S_OUT;
                end
            end

            // The in-flight response belongs to the old PC; swallow it.
            S_DISCARD: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                end
                if (icache_resp_valid) begin
                    state_d = S_REQ;
                end
            end

            S_OUT: begin
                if (redirect_valid) begin
                    valid_1_d = 1'b0;
                    valid_2_d = 1'b0;
                    pc_d      = redirect_aligned;
                    state_d   = S_REQ;
                end else if (!stall) begin
                    valid_1_d = 1'b0;
                    valid_2_d = 1'b0;
                    pc_d      = pc_q + pc_step;
                    state_d   = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch sequencer.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst1;
    logic [31:0] icache_resp_inst2;
    logic [31:0] inst_1_o;
    logic [31:0] inst_2_o;
    logic [31:0] pc_1_o;
    logic [31:0] pc_2_o;
    logic        valid_1_o;
    logic        valid_2_o;
    logic        flush_o;

    fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .icache_req_valid  (icache_req_valid),
        .icache_req_ready  (icache_req_ready),
        .icache_req_addr   (icache_req_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_inst1 (icache_resp_inst1),
        .icache_resp_inst2 (icache_resp_inst2),
        .inst_1_o          (inst_1_o),
        .inst_2_o          (inst_2_o),
        .pc_1_o            (pc_1_o),
        .pc_2_o            (pc_2_o),
        .valid_1_o         (valid_1_o),
        .valid_2_o         (valid_2_o),
        .flush_o           (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fetch PC, outstanding requests (1 = stale), delivered pair.
    logic [31:0] m_pc;
    bit          pend[$];
    logic [31:0] m_i1, m_i2, m_p1, m_p2;
    bit          m_v1, m_v2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        pend.delete();
        m_i1 = '0; m_i2 = '0; m_p1 = '0; m_p2 = '0;
        m_v1 = 1'b0; m_v2 = 1'b0;
    endtask

    task automatic idle_inputs();
        stall = 0; redirect_valid = 0; redirect_pc = '0;
        icache_req_ready = 0; icache_resp_valid = 0;
        icache_resp_inst1 = '0; icache_resp_inst2 = '0;
    endtask

    // One clock: drive inputs, compare DUT with model, then advance the model.
    task automatic step(input bit stl, input bit rv, input logic [31:0] rpc, input bit rdy,
                        input bit rsp, input logic [31:0] d1, input logic [31:0] d2);
        bit exp_req;
        bit st;
        @(negedge clk);
        stall = stl; redirect_valid = rv; redirect_pc = rpc;
        icache_req_ready = rdy; icache_resp_valid = rsp;
        icache_resp_inst1 = d1; icache_resp_inst2 = d2;
        #1;
        exp_req = !rv && (pend.size() == 0) && !m_v1;
        check("flush", flush_o, rv);
        check("req_valid", icache_req_valid, exp_req);
        if (exp_req) check("req_addr", icache_req_addr, m_pc & ~32'h7);
        check("valid_1", valid_1_o, m_v1);
        check("valid_2", valid_2_o, m_v2);
        check("inst_1", inst_1_o, m_i1);
        check("inst_2", inst_2_o, m_i2);
        check("pc_1", pc_1_o, m_p1);
        check("pc_2", pc_2_o, m_p2);

        if (rv) begin
            m_pc = rpc & ~32'h3;
            m_v1 = 0; m_v2 = 0;
            foreach (pend[i]) pend[i] = 1'b1;
            if (rsp && pend.size() > 0) void'(pend.pop_front());
        end else if (rsp && pend.size() > 0) begin
            st = pend.pop_front();
            if (!st) begin
                m_p1 = m_pc;
                m_p2 = m_pc + 32'd4;
                m_v1 = 1'b1;
                if (m_pc[2]) begin
                    m_i1 = d2; m_i2 = '0; m_v2 = 1'b0;
                end else begin
                    m_i1 = d1; m_i2 = d2; m_v2 = 1'b1;
                end
            end
        end else if (m_v1) begin
            if (!stl) begin
                m_v1 = 0; m_v2 = 0;
                m_pc = m_pc + (m_pc[2] ? 32'd4 : 32'd8);
            end
        end else if (exp_req && rdy) begin
            pend.push_back(1'b0);
        end
    endtask

    initial begin
        bit          rv, rsp, stl, rdy;
        logic [31:0] rpc;

        idle_inputs();
        model_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #5;
        check("reset_valid_1", valid_1_o, 0);
        check("reset_pc_1", pc_1_o, 0);
        check("reset_inst_2", inst_2_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Plain aligned fetch.
        step(0, 0, 0, 1, 0, 0, 0);
        check("t1_addr", icache_req_addr, 32'h1c000000);
        step(0, 0, 0, 0, 1, 32'h11, 32'h22);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t1_pc_1", pc_1_o, 32'h1c000000);
        check("t1_pc_2", pc_2_o, 32'h1c000004);
        check("t1_inst_1", inst_1_o, 32'h11);
        check("t1_valid_2", valid_2_o, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t1_next_addr", icache_req_addr, 32'h1c000008);

        // Redirect in REQ to an odd word: single-slot delivery.
        step(0, 1, 32'h1c000107, 1, 0, 0, 0);
        check("t2_no_req", icache_req_valid, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t2_addr", icache_req_addr, 32'h1c000100);
        step(0, 0, 0, 0, 1, 32'haaa, 32'hbbb);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t2_inst_1", inst_1_o, 32'hbbb);
        check("t2_pc_1", pc_1_o, 32'h1c000104);
        check("t2_valid_2", valid_2_o, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t2_next_addr", icache_req_addr, 32'h1c000108);

        // Redirect in WAIT, stale response arrives later.
        step(0, 1, 32'h1c000200, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t3_discard_no_req", icache_req_valid, 0);
        step(0, 0, 0, 1, 1, 32'hdead, 32'hbeef);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t3_valid_1", valid_1_o, 0);
        check("t3_addr", icache_req_addr, 32'h1c000200);

        // Redirect coincident with response.
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 32'h1c000300, 0, 1, 32'h1, 32'h2);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t4_valid_1", valid_1_o, 0);
        check("t4_addr", icache_req_addr, 32'h1c000300);

        // Stall holds the delivered pair.
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h33, 32'h44);
        repeat (4) begin
            step(1, 0, 0, 1, 0, 0, 0);
            check("t5_hold_inst_2", inst_2_o, 32'h44);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t5_addr", icache_req_addr, 32'h1c000308);

        // Address wrap at the top of the space.
        step(0, 1, 32'hfffffff8, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h5, 32'h6);
        step(0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc_2", pc_2_o, 32'hfffffffc);
        step(0, 0, 0, 0, 0, 0, 0);
        check("wrap_addr", icache_req_addr, 32'h0);

        // Asynchronous reset while a request is outstanding.
        step(0, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_pc_1", pc_1_o, 0);
        check("t6_async_inst_1", inst_1_o, 0);
        check("t6_async_valid_1", valid_1_o, 0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_req_valid", icache_req_valid, 1);
        check("t6_addr", icache_req_addr, RESET_PC);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rv  = ($urandom_range(0, 9) == 0);
            stl = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rsp = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
            rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                               : (32'h1c000000 | (32'($urandom) & 32'hfff));
            step(stl, rv, rpc, rdy, rsp, 32'($urandom), 32'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Front-end fetch sequencer. Generates the fetch PC, issues one 8-byte (two-instruction) request at a time to the ICache, and hands the returned instruction pair to the IF stage register.
- Outputs feed the IF register directly as inst_1/inst_2/pc_1/pc_2 plus slot valids.
- Applies backend redirects (branch/exception) and discards stale in-flight ICache responses.
- Drives flush_o to the IF register.

Parameters:
RESET_PC  32'h1c000000  fetch address after reset
ADDR_W    32            PC/address width

Ports:
clk                 in   1       clock
rst                 in   1       asynchronous, active-high reset
stall               in   1       backend not ready; hold delivered pair
redirect_valid      in   1       redirect PC this cycle (priority over all)
redirect_pc         in   ADDR_W  new fetch PC; bits [1:0] ignored (treated as 0)
icache_req_valid    out  1       fetch request valid
icache_req_ready    in   1       ICache accepts request
icache_req_addr     out  ADDR_W  request address, 8-byte aligned
icache_resp_valid   in   1       response for oldest accepted request
icache_resp_inst1   in   32      word at addr+0
icache_resp_inst2   in   32      word at addr+4
inst_1_o            out  32      slot-1 instruction
inst_2_o            out  32      slot-2 instruction
pc_1_o              out  ADDR_W  slot-1 PC
pc_2_o              out  ADDR_W  slot-2 PC
valid_1_o           out  1       slot-1 valid
valid_2_o           out  1       slot-2 valid
flush_o             out  1       flush IF register

Behaviour:
- Reset (async, any state): state=REQ, pc=RESET_PC, all inst/pc outputs 0, valid_1_o=valid_2_o=0.
- At most one request outstanding. Responses return in order.
- icache_req_valid=1 only in REQ, and only when redirect_valid=0.
- icache_req_addr = {pc[ADDR_W-1:3],3'b000}.
- flush_o = redirect_valid (combinational).

State REQ:
- redirect_valid: pc<=redirect_pc&~3; stay REQ. No request is issued that cycle.
- Otherwise, on req_valid&req_ready: go to WAIT.

State WAIT:
- redirect_valid (with or without resp_valid): pc<=redirect_pc.
  - If resp_valid the same cycle, the response is dropped; go to REQ.
  - Otherwise go to DISCARD.
- resp_valid, no redirect: latch outputs, go to OUT.

State DISCARD:
- Wait for the stale response. resp_valid -> drop it, go to REQ.
- redirect_valid here updates pc and stays in DISCARD. If resp_valid arrives the same cycle, go to REQ.

State OUT (valids high):
- redirect_valid: clear both valids; pc<=redirect_pc; go to REQ.
- Else if stall: hold all outputs.
- Else: clear valids, pc<=pc_next, go to REQ.

Latch rule on response:
- pc[2]==0: inst_1_o=resp_inst1, inst_2_o=resp_inst2, pc_1_o=pc, pc_2_o=pc+4, valid_1_o=valid_2_o=1, pc_next=pc+8.
- pc[2]==1: inst_1_o=resp_inst2, pc_1_o=pc, inst_2_o=0, pc_2_o=pc+4, valid_1_o=1, valid_2_o=0, pc_next=pc+4.

Timing and arithmetic:
- Latency: request accepted in cycle N, response in cycle M>N, outputs valid in cycle M+1. Back-to-back fetch uses at most 1 request per 3 cycles (REQ, WAIT, OUT minimum).
- PC arithmetic is modulo 2^ADDR_W; 32'hfffffff8+8 wraps to 0.
- Outputs in non-OUT states keep their last values with valids 0.

Test Plan:
1. Release reset, ready=1, resp one cycle after accept with inst1=32'h11, inst2=32'h22 -> req_addr=32'h1c000000; next cycle pc_1_o=32'h1c000000, pc_2_o=32'h1c000004, both valid; next request addr 32'h1c000008.
2. redirect_pc=32'h1c000104 in REQ -> flush_o=1 that cycle, no request; next request addr 32'h1c000100; response delivers only slot 1: inst_1_o=resp_inst2, pc_1_o=32'h1c000104, valid_2_o=0; following request addr 32'h1c000108.
3. Redirect to 32'h1c000200 in WAIT before the response -> stale response two cycles later is dropped (valids stay 0); next request addr 32'h1c000200.
4. Redirect and resp_valid in the same WAIT cycle -> response dropped, no valid output; state REQ with pc=redirect_pc.
5. stall=1 for 4 cycles in OUT -> outputs and valids stable for 4 cycles, no new request. stall=0 -> valids drop next cycle and the request for pc+8 issues.
6. Assert rst mid-WAIT -> outputs clear immediately (asynchronous). After release, req_addr=RESET_PC and req_valid=1 in the first cycle.
